// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, field encodings and the 19-bit control bundle.
// Imported by the decoder, the queue and its interface.
package decode_pkg;

  localparam logic [6:0] OP_BUBBLE = 7'b0000000;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MD   = 7'b0000001;

  localparam logic [2:0] LS_W  = 3'b000;
  localparam logic [2:0] LS_B  = 3'b001;
  localparam logic [2:0] LS_BU = 3'b010;
  localparam logic [2:0] LS_H  = 3'b011;
  localparam logic [2:0] LS_HU = 3'b100;

  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_W    = 2'b01;
  localparam logic [1:0] MW_H    = 2'b10;
  localparam logic [1:0] MW_B    = 2'b11;

  localparam logic [2:0] IMM_I  = 3'b000;
  localparam logic [2:0] IMM_S  = 3'b001;
  localparam logic [2:0] IMM_B  = 3'b010;
  localparam logic [2:0] IMM_J  = 3'b011;
  localparam logic [2:0] IMM_SH = 3'b100;
  localparam logic [2:0] IMM_U  = 3'b101;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_FN  = 2'b10;
  localparam logic [1:0] ALU_MD  = 2'b11;

  localparam logic [1:0] ASRC_RS1  = 2'b00;
  localparam logic [1:0] ASRC_ZERO = 2'b01;
  localparam logic [1:0] ASRC_PC   = 2'b10;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // Field order is the external bundle layout, MSB first.
  typedef struct packed {
    logic       reg_write;
    logic [2:0] imm_src;
    logic [1:0] alu_a_src;
    logic       alu_b_src;
    logic [1:0] mem_write;
    logic [1:0] result_src;
    logic       branch;
    logic [1:0] alu_op;
    logic       jump;
    logic [2:0] load_size;
    logic       pc_target_alu_src;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/decode_queue_if.sv
// Producer-side and consumer-side handshakes of the decode queue.
// The queue takes the slave view; fetch/execute (or a bench) take the master view.
interface decode_queue_if #(
  parameter int unsigned XLEN = 32
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_instr;
  logic [XLEN-1:0]      in_pc;

  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_instr;
  logic [XLEN-1:0]      out_pc;
  decode_pkg::ctrl_t    out_ctrl;
  logic                 out_muldiv;
  logic                 out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_ctrl, out_muldiv, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_ctrl, out_muldiv, out_illegal
  );

endinterface

// File: rtl/rv_decode_comb.sv
// Pure combinational RV32I(+M) main decoder: instruction word to control bundle.
// Illegal encodings yield an all-zero bundle with illegal set, never X.
module rv_decode_comb
  import decode_pkg::*;
#(
  parameter bit M_EXT = 1'b0
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        muldiv,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  ctrl_t      ctrl_raw;
  logic       muldiv_raw;
  logic       illegal_raw;

  assign opcode        = instr[6:0];
  assign funct3        = instr[14:12];
  assign funct7        = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    ctrl_raw    = CTRL_NOP;
    muldiv_raw  = 1'b0;
    illegal_raw = 1'b0;

    unique case (opcode)
      OP_LOAD: begin
        ctrl_raw.reg_write  = 1'b1;
        ctrl_raw.imm_src    = IMM_I;
        ctrl_raw.alu_b_src  = 1'b1;
        ctrl_raw.result_src = RES_MEM;
        ctrl_raw.alu_op     = ALU_ADD;
        unique case (funct3)
          3'b000:  ctrl_raw.load_size = LS_B;
          3'b001:  ctrl_raw.load_size = LS_H;
          3'b010:  ctrl_raw.load_size = LS_W;
          3'b100:  ctrl_raw.load_size = LS_BU;
          3'b101:  ctrl_raw.load_size = LS_HU;
          default: illegal_raw = 1'b1;
        endcase
      end

      OP_STORE: begin
        ctrl_raw.imm_src   = IMM_S;
        ctrl_raw.alu_b_src = 1'b1;
        unique case (funct3)
          3'b000:  ctrl_raw.mem_write = MW_B;
          3'b001:  ctrl_raw.mem_write = MW_H;
          3'b010:  ctrl_raw.mem_write = MW_W;
          default: illegal_raw = 1'b1;
        endcase
      end

      OP_REG: begin
        ctrl_raw.reg_write = 1'b1;
        ctrl_raw.alu_op    = ALU_FN;
        if (funct7 == F7_BASE) begin
          illegal_raw = 1'b0;
        end else if (funct7 == F7_ALT) begin
          // Only sub and sra have an alternate encoding.
          illegal_raw = !((funct3 == 3'b000) || (funct3 == 3'b101));
        end else if ((funct7 == F7_MD) && M_EXT) begin
          ctrl_raw.alu_op = ALU_MD;
          muldiv_raw      = 1'b1;
        end else begin
          illegal_raw = 1'b1;
        end
      end

      OP_BRANCH: begin
        ctrl_raw.imm_src = IMM_B;
        ctrl_raw.branch  = 1'b1;
        ctrl_raw.alu_op  = ALU_BR;
        illegal_raw      = (funct3 == 3'b010) || (funct3 == 3'b011);
      end

      OP_IMM: begin
        ctrl_raw.reg_write = 1'b1;
        ctrl_raw.alu_b_src = 1'b1;
        ctrl_raw.alu_op    = ALU_FN;
        if (funct3 == 3'b001) begin
          ctrl_raw.imm_src = IMM_SH;
          illegal_raw      = (funct7 != F7_BASE);
        end else if (funct3 == 3'b101) begin
          ctrl_raw.imm_src = IMM_SH;
          illegal_raw      = (funct7 != F7_BASE) && (funct7 != F7_ALT);
        end else begin
          ctrl_raw.imm_src = IMM_I;
        end
      end

      OP_JAL: begin
        ctrl_raw.reg_write  = 1'b1;
        ctrl_raw.imm_src    = IMM_J;
        ctrl_raw.result_src = RES_PC4;
        ctrl_raw.jump       = 1'b1;
      end

      OP_JALR: begin
        ctrl_raw.reg_write         = 1'b1;
        ctrl_raw.imm_src           = IMM_I;
        ctrl_raw.alu_b_src         = 1'b1;
        ctrl_raw.result_src        = RES_PC4;
        ctrl_raw.jump              = 1'b1;
        ctrl_raw.pc_target_alu_src = 1'b1;
        illegal_raw                = (funct3 != 3'b000);
      end

      OP_LUI: begin
        ctrl_raw.reg_write = 1'b1;
        ctrl_raw.imm_src   = IMM_U;
        ctrl_raw.alu_a_src = ASRC_ZERO;
        ctrl_raw.alu_b_src = 1'b1;
      end

      OP_AUIPC: begin
        ctrl_raw.reg_write = 1'b1;
        ctrl_raw.imm_src   = IMM_U;
        ctrl_raw.alu_a_src = ASRC_PC;
        ctrl_raw.alu_b_src = 1'b1;
      end

      OP_BUBBLE: begin
        ctrl_raw = CTRL_NOP;
      end

      default: illegal_raw = 1'b1;
    endcase
  end

  // Illegal entries must not carry any side-effecting control bits.
  always_comb begin
    ctrl    = illegal_raw ? CTRL_NOP : ctrl_raw;
    muldiv  = illegal_raw ? 1'b0 : muldiv_raw;
    illegal = illegal_raw;
  end

endmodule

// File: rtl/decode_queue.sv
// Decode-on-entry instruction FIFO: decodes each accepted instruction and holds
// it with its PC until the execute stage takes it from the head.
module decode_queue
  import decode_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4,
  parameter bit          M_EXT = 1'b0,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  decode_queue_if.slave    dq,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    ctrl_t           ctrl;
    logic            muldiv;
    logic            illegal;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           entry_in;
  entry_t           head;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  ctrl_t            dec_ctrl;
  logic             dec_muldiv;
  logic             dec_illegal;

  rv_decode_comb #(
    .M_EXT (M_EXT)
  ) u_decode (
    .instr   (dq.in_instr),
    .ctrl    (dec_ctrl),
    .muldiv  (dec_muldiv),
    .illegal (dec_illegal)
  );

  always_comb begin
    entry_in.instr   = dq.in_instr;
    entry_in.pc      = dq.in_pc;
    entry_in.ctrl    = dec_ctrl;
    entry_in.muldiv  = dec_muldiv;
    entry_in.illegal = dec_illegal;
  end

  // No full-bypass: a push while full is refused even if the head pops this cycle.
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = dq.in_valid && !full;
  assign pop   = !empty && dq.out_ready;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; out_valid gates every read.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= entry_in;
    end
  end

  assign head = mem_q[rd_ptr_q];

  assign dq.in_ready    = !full;
  assign dq.out_valid   = !empty;
  assign dq.out_instr   = head.instr;
  assign dq.out_pc      = head.pc;
  assign dq.out_ctrl    = head.ctrl;
  assign dq.out_muldiv  = head.muldiv;
  assign dq.out_illegal = head.illegal;
  assign count          = count_q;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: an M_EXT=0 and an M_EXT=1 instance share one stimulus stream
// and are compared against a queue-based reference model with an arithmetic decoder.
module tb_decode_queue;
  import decode_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic [31:0]      in_instr = '0;
  logic [XLEN-1:0]  in_pc = '0;
  logic             out_ready = 1'b0;
  logic [CNT_W-1:0] count0, count1;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  decode_queue_if #(.XLEN(XLEN)) if0 ();
  decode_queue_if #(.XLEN(XLEN)) if1 ();

  assign if0.in_valid  = in_valid;
  assign if0.in_instr  = in_instr;
  assign if0.in_pc     = in_pc;
  assign if0.out_ready = out_ready;
  assign if1.in_valid  = in_valid;
  assign if1.in_instr  = in_instr;
  assign if1.in_pc     = in_pc;
  assign if1.out_ready = out_ready;

  decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .M_EXT(1'b0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .dq    (if0),
    .count (count0)
  );

  decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .M_EXT(1'b1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .dq    (if1),
    .count (count1)
  );

  typedef struct {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } item_t;

  item_t mq[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Returns {illegal, muldiv, ctrl[18:0]} built by weighting each field into place.
  function automatic logic [20:0] ref_decode(input logic [31:0] w, input bit mext);
    int op, f3, f7;
    int rw, imm, asrc, bsrc, mw, res, br, aop, j, ls, pct, ctrl;
    bit ok, md;
    op = int'(w[6:0]);
    f3 = int'(w[14:12]);
    f7 = int'(w[31:25]);
    {rw, imm, asrc, bsrc, mw, res, br, aop, j, ls, pct} = '0;
    ok = 1'b1;
    md = 1'b0;
    case (op)
      'h03: begin
        rw = 1; bsrc = 1; res = 1;
        ok = f3 inside {0, 1, 2, 4, 5};
        ls = (f3 == 2) ? 0 : (f3 == 0) ? 1 : (f3 == 4) ? 2 : (f3 == 1) ? 3 : 4;
      end
      'h23: begin
        imm = 1; bsrc = 1;
        ok = (f3 <= 2);
        mw = 3 - f3;
      end
      'h33: begin
        rw = 1; aop = 2;
        if (f7 == 0) ok = 1'b1;
        else if (f7 == 'h20) ok = (f3 == 0) || (f3 == 5);
        else if (f7 == 1 && mext) begin aop = 3; md = 1'b1; end
        else ok = 1'b0;
      end
      'h63: begin
        imm = 2; br = 1; aop = 1;
        ok = !((f3 == 2) || (f3 == 3));
      end
      'h13: begin
        rw = 1; bsrc = 1; aop = 2;
        imm = (f3 == 1 || f3 == 5) ? 4 : 0;
        if (f3 == 1) ok = (f7 == 0);
        if (f3 == 5) ok = (f7 == 0) || (f7 == 'h20);
      end
      'h6f: begin rw = 1; imm = 3; res = 2; j = 1; end
      'h67: begin rw = 1; bsrc = 1; res = 2; j = 1; pct = 1; ok = (f3 == 0); end
      'h37: begin rw = 1; imm = 5; asrc = 1; bsrc = 1; end
      'h17: begin rw = 1; imm = 5; asrc = 2; bsrc = 1; end
      'h00: ;
      default: ok = 1'b0;
    endcase
    ctrl = rw * (2 ** 18) + imm * (2 ** 15) + asrc * (2 ** 13) + bsrc * (2 ** 12)
         + mw * (2 ** 10) + res * (2 ** 8) + br * (2 ** 7) + aop * (2 ** 5)
         + j * (2 ** 4) + ls * 2 + pct;
    if (!ok) begin
      ctrl = 0;
      md   = 1'b0;
    end
    return {!ok, md, ctrl[18:0]};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 10))
      0: w[6:0] = 7'h03;
      1: w[6:0] = 7'h23;
      2: w[6:0] = 7'h33;
      3: w[6:0] = 7'h63;
      4: w[6:0] = 7'h13;
      5: w[6:0] = 7'h6f;
      6: w[6:0] = 7'h67;
      7: w[6:0] = 7'h37;
      8: w[6:0] = 7'h17;
      9: w[6:0] = 7'h00;
      default: ;
    endcase
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h01;
      default: ;
    endcase
    return w;
  endfunction

  task automatic compare_all();
    int          n;
    logic [20:0] d0, d1;
    n = mq.size();
    check("count0", 64'(count0), 64'(n));
    check("count1", 64'(count1), 64'(n));
    check("in_ready0", 64'(if0.in_ready), 64'(n != DEPTH));
    check("in_ready1", 64'(if1.in_ready), 64'(n != DEPTH));
    check("out_valid0", 64'(if0.out_valid), 64'(n != 0));
    check("out_valid1", 64'(if1.out_valid), 64'(n != 0));
    if (n != 0) begin
      d0 = ref_decode(mq[0].instr, 1'b0);
      d1 = ref_decode(mq[0].instr, 1'b1);
      check("instr0", 64'(if0.out_instr), 64'(mq[0].instr));
      check("pc0", 64'(if0.out_pc), 64'(mq[0].pc));
      check("pc1", 64'(if1.out_pc), 64'(mq[0].pc));
      check("dec0", 64'({if0.out_illegal, if0.out_muldiv, if0.out_ctrl}), 64'(d0));
      check("dec1", 64'({if1.out_illegal, if1.out_muldiv, if1.out_ctrl}), 64'(d1));
    end
  endtask

  // One clock: predict the transfer from pre-edge state, then compare after the edge.
  task automatic cycle();
    bit    do_push, do_pop;
    item_t it;
    do_push = in_valid && (mq.size() != DEPTH);
    do_pop  = out_ready && (mq.size() != 0);
    @(posedge clk);
    #1;
    if (flush) begin
      mq.delete();
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        it.instr = in_instr;
        it.pc    = in_pc;
        mq.push_back(it);
      end
    end
    compare_all();
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] pc,
                       input logic rdy);
    in_valid  = v;
    in_instr  = w;
    in_pc     = pc;
    out_ready = rdy;
  endtask

  initial begin
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    check("rst_count", 64'(count0), 64'd0);
    check("rst_out_valid", 64'(if0.out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    compare_all();
    check("rst_in_ready", 64'(if0.in_ready), 64'd1);

    // lw x1,0(x2) reaches the head one cycle after the push.
    drive(1'b1, 32'h0001_2083, 32'h100, 1'b1);
    cycle();
    check("t1_ctrl", 64'(if0.out_ctrl), 64'(19'b1_000_00_1_00_01_0_00_0_000_0));
    check("t1_illegal", 64'(if0.out_illegal), 64'd0);
    check("t1_count", 64'(count0), 64'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    cycle();

    // Five addi with the consumer stalled: the fifth is held off.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, {12'(i), 5'd0, 3'b000, 5'(i + 1), 7'h13}, 32'h200 + 32'(4 * i), 1'b0);
      check("t2_in_ready", 64'(if0.in_ready), 64'(i < 4));
      cycle();
    end
    check("t2_full", 64'(count0), 64'd4);
    for (int i = 0; i < 4; i++) begin
      out_ready = 1'b1;
      in_valid  = 1'b0;
      check("t2_order", 64'(if0.out_pc), 64'(32'h200 + 32'(4 * i)));
      cycle();
    end

    // mul: illegal without M, muldiv with M.
    drive(1'b1, 32'h0220_8033, 32'h300, 1'b0);
    cycle();
    check("t3_ill_m0", 64'(if0.out_illegal), 64'd1);
    check("t3_ctrl_m0", 64'(if0.out_ctrl), 64'd0);
    check("t3_md_m1", 64'(if1.out_muldiv), 64'd1);
    check("t3_aluop_m1", 64'(if1.out_ctrl.alu_op), 64'(2'b11));
    check("t3_rw_m1", 64'(if1.out_ctrl.reg_write), 64'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    cycle();

    // Flush beats a concurrent push.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h0000_0013, 32'h400 + 32'(4 * i), 1'b0);
      cycle();
    end
    drive(1'b1, 32'h0000_006f, 32'h4f0, 1'b0);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("t4_count", 64'(count0), 64'd0);
    check("t4_valid", 64'(if0.out_valid), 64'd0);
    in_valid = 1'b0;
    cycle();
    check("t4_not_queued", 64'(count0), 64'd0);

    // Full + push + pop: only the pop happens; then a steady stream across the wrap.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h0000_0037, 32'h500 + 32'(4 * i), 1'b0);
      cycle();
    end
    drive(1'b1, 32'h0000_0017, 32'h5f0, 1'b1);
    cycle();
    check("t5_count3", 64'(count0), 64'd3);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    cycle();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h0000_0033, 32'h600 + 32'(4 * i), 1'b1);
      cycle();
      check("t5_hold2", 64'(count0), 64'd2);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    cycle();
    cycle();

    // Illegal branch and the bubble.
    drive(1'b1, 32'h0020_A063, 32'h700, 1'b0);
    cycle();
    check("t6_br_ill", 64'(if0.out_illegal), 64'd1);
    check("t6_br_branch", 64'(if0.out_ctrl.branch), 64'd0);
    drive(1'b1, 32'h0000_0000, 32'h704, 1'b1);
    cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    check("t6_bub_ill", 64'(if0.out_illegal), 64'd0);
    check("t6_bub_ctrl", 64'(if0.out_ctrl), 64'd0);
    cycle();

    // Asynchronous reset mid-stream drops everything.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h0000_2003, 32'h800 + 32'(4 * i), 1'b0);
      cycle();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_count", 64'(count0), 64'd0);
    check("mid_rst_valid", 64'(if1.out_valid), 64'd0);
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Random traffic with occasional flushes.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = (i < 1500) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 40) == 0);
      in_instr  = rand_instr();
      in_pc     = $urandom;
      cycle();
    end
    flush = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
